rr_mux_8_way: RTL and testbench

// - Merges 8 valid/ready input channels onto one registered output channel with round-robin fairness.
// - Reports which channel each output word came from on out_select, the same 3-bit encoding dmux_8_way consumes.
// - Gathers traffic from up to 8 producers; a downstream dmux_8_way fans it back out by out_select.

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_arbiter_8.sv | 41 ++++
 rtl/rr_mux_8_way.sv | 116 +++++++++++
 tb/tb_rr_mux_8_way.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and types for the 8-way round-robin mux
// Purpose: channel count, select encoding width, select type and output-stage state encoding.
// Ports: none (package).
package mux_pkg;

   localparam int N_CH  = 8;
   localparam int SEL_W = 3;

   typedef logic [SEL_W-1:0] sel_t;

   // Output register occupancy: EMPTY holds no word, FULL presents a word on out_*.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

endpackage : mux_pkg

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - combinational 8-way round-robin arbiter
// Purpose: pick the first requesting index at or above ptr, wrapping 7->0.
// Ports:
//   req     in   8   request vector
//   ptr     in   3   highest-priority index for this cycle
//   en      in   1   grant enable; gnt is forced to zero when low
//   gnt     out  8   one-hot grant (zero when en=0 or no request)
//   gnt_idx out  3   index of the winning request (valid when any=1)
//   any     out  1   at least one request is present (independent of en)
module rr_arbiter_8
   import mux_pkg::*;
(
   input  logic [N_CH-1:0] req,
   input  sel_t            ptr,
   input  logic            en,
   output logic [N_CH-1:0] gnt,
   output sel_t            gnt_idx,
   output logic            any
);

   logic found;
   sel_t cand;

   // Walk the eight positions starting at ptr; 3-bit addition wraps 7->0 for free.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < N_CH; k++) begin
         cand = ptr + sel_t'(k);
         if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign any = |req;
   assign gnt = (en && found) ? (N_CH'(1) << gnt_idx) : '0;

endmodule : rr_arbiter_8

// File: rtl/rr_mux_8_way.sv
// rtl/rr_mux_8_way.sv - 8-to-1 valid/ready merge with round-robin fairness and registered output
// Purpose: merge eight producer channels onto one registered output, tagging each word with
//          its source channel on out_select.
// Ports:
//   clk         in   1          rising-edge clock
//   rst_n       in   1          asynchronous active-low reset
//   in_data     in   8*WIDTH    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid    in   8          per-channel valid
//   in_ready    out  8          per-channel ready, one-hot or zero
//   out_data    out  WIDTH      registered output word
//   out_select  out  3          source channel of out_data
//   out_valid   out  1          registered output valid
//   out_ready   in   1          downstream ready
module rr_mux_8_way
   import mux_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_select,
   output logic                  out_valid,
   input  logic                  out_ready
);

   out_state_e        state_q;
   out_state_e        state_d;
   sel_t              rr_ptr;
   logic              load_en;
   logic              arb_en;
   logic [N_CH-1:0]   gnt;
   sel_t              gnt_idx;
   logic              arb_any;
   logic              xfer;
   logic [WIDTH-1:0]  sel_data;

   // The output register can take a new word when empty or when its word leaves this cycle.
   assign load_en = !out_valid || out_ready;

   // Gating with rst_n keeps in_ready low for the whole reset, not only after the first edge.
   assign arb_en = load_en && rst_n;

   rr_arbiter_8 u_arb (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (arb_any)
   );

   assign in_ready = gnt;
   assign xfer     = arb_any && arb_en;

   // Data mux indexed by the winning channel.
   always_comb begin
      sel_data = in_data[WIDTH-1:0];
      for (int i = 0; i < N_CH; i++) begin
         if (gnt_idx == sel_t'(i)) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (xfer) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            // With out_ready high the word drains; a simultaneous transfer refills it.
            if (out_ready && !xfer) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Output logic
   always_comb begin
      out_valid = (state_q == ST_FULL);
   end

   // Datapath and priority pointer; both move only on a transfer so idle cycles keep priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data   <= '0;
         out_select <= '0;
         rr_ptr     <= '0;
      end else if (xfer) begin
         out_data   <= sel_data;
         out_select <= gnt_idx;
         rr_ptr     <= gnt_idx + sel_t'(1);
      end
   end

endmodule : rr_mux_8_way

// File: tb/tb_rr_mux_8_way.sv
// tb/tb_rr_mux_8_way.sv - directed table-driven bench for rr_mux_8_way
module tb_rr_mux_8_way;

   localparam int WIDTH = 16;

   logic              clk;
   logic              rst_n;
   logic [8*WIDTH-1:0] in_data;
   logic [7:0]        in_valid;
   logic [7:0]        in_ready;
   logic [WIDTH-1:0]  out_data;
   logic [2:0]        out_select;
   logic              out_valid;
   logic              out_ready;

   int n_tests;
   int n_fail;

   rr_mux_8_way #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_select (out_select),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] v;
      logic       ordy;
      logic [7:0] exp_rdy;
      logic       exp_ov;
      logic [2:0] exp_sel;
      logic [2:0] exp_ptr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [7:0] v, logic ordy, logic [7:0] rdy,
                               logic ov, logic [2:0] sel, logic [2:0] ptr);
      vec_t r;
      r.v = v; r.ordy = ordy; r.exp_rdy = rdy; r.exp_ov = ov; r.exp_sel = sel; r.exp_ptr = ptr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = 16'h0A00 + 16'(i);

      // Reset with every channel requesting
      rst_n     = 1'b0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", 32'(in_ready), 32'h0);
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset out_select", 32'(out_select), 32'h0);
      chk("reset out_data", 32'(out_data), 32'h0);
      chk("reset rr_ptr", 32'(dut.rr_ptr), 32'h0);
      rst_n = 1'b1;

      // Full contention: 0..7 then wrap to 0
      tbl.push_back(mk(8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 3'd1));
      tbl.push_back(mk(8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 3'd2));
      tbl.push_back(mk(8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 3'd3));
      tbl.push_back(mk(8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 3'd4));
      tbl.push_back(mk(8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 3'd5));
      tbl.push_back(mk(8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 3'd6));
      tbl.push_back(mk(8'hFF, 1'b1, 8'h40, 1'b1, 3'd6, 3'd7));
      tbl.push_back(mk(8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 3'd0));
      tbl.push_back(mk(8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 3'd1));
      // Grant ch6, then sparse 0000_0101 with wrap
      tbl.push_back(mk(8'h40, 1'b1, 8'h40, 1'b1, 3'd6, 3'd7));
      tbl.push_back(mk(8'h05, 1'b1, 8'h01, 1'b1, 3'd0, 3'd1));
      tbl.push_back(mk(8'h05, 1'b1, 8'h04, 1'b1, 3'd2, 3'd3));
      tbl.push_back(mk(8'h05, 1'b1, 8'h01, 1'b1, 3'd0, 3'd1));
      // Backpressure for 3 cycles with ch3 pending, then release
      tbl.push_back(mk(8'h08, 1'b0, 8'h00, 1'b1, 3'd0, 3'd1));
      tbl.push_back(mk(8'h08, 1'b0, 8'h00, 1'b1, 3'd0, 3'd1));
      tbl.push_back(mk(8'h08, 1'b0, 8'h00, 1'b1, 3'd0, 3'd1));
      tbl.push_back(mk(8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 3'd4));
      // Drain: single word on ch5, then idle
      tbl.push_back(mk(8'h20, 1'b1, 8'h20, 1'b1, 3'd5, 3'd6));
      tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 3'd6));
      tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 3'd6));
      // Empty stage accepts even with out_ready low; then hold, then drain
      tbl.push_back(mk(8'h02, 1'b0, 8'h02, 1'b1, 3'd1, 3'd2));
      tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 3'd1, 3'd2));
      tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd1, 3'd2));

      // Apply inputs just after an edge, check in_ready before the next edge, outputs after it
      #1;
      foreach (tbl[i]) begin
         in_valid  = tbl[i].v;
         out_ready = tbl[i].ordy;
         #2;
         chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
         chk($sformatf("v%0d out_select", i), 32'(out_select), 32'(tbl[i].exp_sel));
         chk($sformatf("v%0d rr_ptr", i), 32'(dut.rr_ptr), 32'(tbl[i].exp_ptr));
         if (tbl[i].exp_ov)
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'h0A00 + 32'(tbl[i].exp_sel));
      end

      // Async reset mid-stream: fill from ptr=2 (grant ch2), hold, then drop rst_n between edges
      in_valid  = 8'hFF;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("pre-reset out_valid", 32'(out_valid), 32'h1);
      chk("pre-reset out_select", 32'(out_select), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset out_valid", 32'(out_valid), 32'h0);
      chk("async reset in_ready", 32'(in_ready), 32'h0);
      chk("async reset rr_ptr", 32'(dut.rr_ptr), 32'h0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #2;
      chk("post-reset in_ready", 32'(in_ready), 32'h01);
      @(posedge clk);
      #1;
      chk("post-reset out_valid", 32'(out_valid), 32'h1);
      chk("post-reset out_select", 32'(out_select), 32'h0);
      chk("post-reset out_data", 32'(out_data), 32'h0A00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rr_mux_8_way
